// File: rtl/noc_spine_pkg.sv
// Shared spine-lane definitions: flit geometry and the link state encoding
// used by every spine_lane_bridge instance.
package noc_spine_pkg;

    localparam int DWIDTH   = 16;
    localparam int ADDR_W   = 6;
    localparam int DEST_LSB = 10;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        UP       = 2'd1,
        DRAIN    = 2'd2
    } link_state_e;

endpackage

// File: rtl/spine_egress_fifo.sv
// Synchronous egress FIFO for one spine lane; the caller guarantees push only
// when not full (or popping) and pop only when not empty.
module spine_egress_fifo #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DWIDTH-1:0]        wdata,
    output logic [DWIDTH-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DWIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;

    // Storage is cleared on reset so the head word reads as zero with nothing queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (level_r == LVL_W'(DEPTH));
    assign empty = (level_r == '0);
    assign level = level_r;

endmodule

// File: rtl/spine_lane_bridge.sv
// Bridges a valid-only router spine port to a valid/ready spine-switch link.
// Define SPINE_BRIDGE_DROP_CNT_EN to build the saturating egress drop counter.
module spine_lane_bridge #(
    parameter int DWIDTH     = noc_spine_pkg::DWIDTH,
    parameter int ADDR_W     = noc_spine_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 8,
    parameter int RX_GAP     = 0,
    parameter int DROP_W     = 8
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          link_en,
    input  logic [DWIDTH-1:0]             rtr_out_data,
    input  logic                          rtr_out_valid,
    output logic [DWIDTH-1:0]             sp_tx_data,
    output logic [ADDR_W-1:0]             sp_tx_dest,
    output logic                          sp_tx_valid,
    input  logic                          sp_tx_ready,
    input  logic [DWIDTH-1:0]             sp_rx_data,
    input  logic                          sp_rx_valid,
    output logic                          sp_rx_ready,
    output logic [DWIDTH-1:0]             rtr_in_data,
    output logic                          rtr_in_valid,
    output logic [ADDR_W-1:0]             rtr_in_dest_addr,
    output logic                          link_up,
    output logic [$clog2(FIFO_DEPTH):0]   egr_level,
    output logic [DROP_W-1:0]             drop_cnt
);

    import noc_spine_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = (RX_GAP > 0) ? $clog2(RX_GAP + 1) : 1;

    link_state_e        state_r;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               tx_valid_s;
    logic               push_s;
    logic               pop_s;
    logic [DWIDTH-1:0]  head_s;
    logic [LVL_W-1:0]   level_s;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [DWIDTH-1:0]  rx_data_r;
    logic [ADDR_W-1:0]  rx_dest_r;
    logic               rx_valid_r;
    logic               rx_accept_s;

    // Egress handshake: a full FIFO still takes a flit when the head leaves that cycle
    always_comb begin
        tx_valid_s = 1'b0;
        pop_s      = 1'b0;
        push_s     = 1'b0;
        if (!fifo_empty_s && (state_r != DISABLED)) begin
            tx_valid_s = 1'b1;
            pop_s      = sp_tx_ready;
        end else begin
            tx_valid_s = 1'b0;
            pop_s      = 1'b0;
        end
        if (rtr_out_valid && (state_r == UP) && (!fifo_full_s || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    spine_egress_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_egress_fifo (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (rtr_out_data),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (level_s)
    );

    // Link state machine; a returning link_en in DRAIN wins over finishing the drain
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r <= DISABLED;
        end else begin
            case (state_r)
                DISABLED: if (link_en)  state_r <= UP;
                UP:       if (!link_en) state_r <= DRAIN;
                DRAIN: begin
                    if (link_en) begin
                        state_r <= UP;
                    end else if (fifo_empty_s) begin
                        state_r <= DISABLED;
                    end
                end
                default:  state_r <= DISABLED;
            endcase
        end
    end

    assign sp_rx_ready = (state_r == UP) && (gap_cnt_r == '0);
    assign rx_accept_s = sp_rx_valid && sp_rx_ready;

    // Ingress re-timing: one-cycle pulse per accepted flit, then RX_GAP idle cycles
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rx_data_r  <= '0;
            rx_dest_r  <= '0;
            rx_valid_r <= 1'b0;
            gap_cnt_r  <= '0;
        end else if (rx_accept_s) begin
            rx_data_r  <= sp_rx_data;
            rx_dest_r  <= sp_rx_data[DWIDTH-1 -: ADDR_W];
            rx_valid_r <= 1'b1;
            gap_cnt_r  <= GAP_W'(RX_GAP);
        end else begin
            rx_valid_r <= 1'b0;
            if (gap_cnt_r != '0) begin
                gap_cnt_r <= gap_cnt_r - 1'b1;
            end
        end
    end

`ifdef SPINE_BRIDGE_DROP_CNT_EN
    logic               drop_s;
    logic [DROP_W-1:0]  drop_cnt_r;

    assign drop_s = rtr_out_valid && !push_s;

    // Saturating count of router flits that could not be queued
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            drop_cnt_r <= '0;
        end else if (drop_s && (drop_cnt_r != '1)) begin
            drop_cnt_r <= drop_cnt_r + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = '0;
`endif

    assign sp_tx_data       = head_s;
    assign sp_tx_dest       = head_s[DWIDTH-1 -: ADDR_W];
    assign sp_tx_valid      = tx_valid_s;
    assign rtr_in_data      = rx_data_r;
    assign rtr_in_valid     = rx_valid_r;
    assign rtr_in_dest_addr = rx_dest_r;
    assign link_up          = (state_r == UP);
    assign egr_level        = level_s;

endmodule

// File: tb/tb_spine_lane_bridge.sv
// Directed bench for spine_lane_bridge (FIFO_DEPTH 8, RX_GAP 2).
module tb_spine_lane_bridge;

    logic        ACLK;
    logic        ARESETn;
    logic        link_en;
    logic [15:0] rtr_out_data;
    logic        rtr_out_valid;
    logic [15:0] sp_tx_data;
    logic [5:0]  sp_tx_dest;
    logic        sp_tx_valid;
    logic        sp_tx_ready;
    logic [15:0] sp_rx_data;
    logic        sp_rx_valid;
    logic        sp_rx_ready;
    logic [15:0] rtr_in_data;
    logic        rtr_in_valid;
    logic [5:0]  rtr_in_dest_addr;
    logic        link_up;
    logic [3:0]  egr_level;
    logic [7:0]  drop_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    spine_lane_bridge #(
        .DWIDTH     (16),
        .ADDR_W     (6),
        .FIFO_DEPTH (8),
        .RX_GAP     (2),
        .DROP_W     (8)
    ) dut (
        .ACLK             (ACLK),
        .ARESETn          (ARESETn),
        .link_en          (link_en),
        .rtr_out_data     (rtr_out_data),
        .rtr_out_valid    (rtr_out_valid),
        .sp_tx_data       (sp_tx_data),
        .sp_tx_dest       (sp_tx_dest),
        .sp_tx_valid      (sp_tx_valid),
        .sp_tx_ready      (sp_tx_ready),
        .sp_rx_data       (sp_rx_data),
        .sp_rx_valid      (sp_rx_valid),
        .sp_rx_ready      (sp_rx_ready),
        .rtr_in_data      (rtr_in_data),
        .rtr_in_valid     (rtr_in_valid),
        .rtr_in_dest_addr (rtr_in_dest_addr),
        .link_up          (link_up),
        .egr_level        (egr_level),
        .drop_cnt         (drop_cnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] drop_exp(input int n);
`ifdef SPINE_BRIDGE_DROP_CNT_EN
        return 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    initial begin
        logic [15:0] exp_data;

        ARESETn = 1'b0; link_en = 1'b0; rtr_out_data = 16'h0; rtr_out_valid = 1'b0;
        sp_tx_ready = 1'b0; sp_rx_data = 16'h0; sp_rx_valid = 1'b0;
        tick(); tick();
        check("rst_link_up", link_up, 32'd0);
        check("rst_tx_valid", sp_tx_valid, 32'd0);
        check("rst_tx_data", sp_tx_data, 32'd0);
        check("rst_level", egr_level, 32'd0);
        check("rst_drop", drop_cnt, 32'd0);
        check("rst_rx_ready", sp_rx_ready, 32'd0);
        check("rst_rin_valid", rtr_in_valid, 32'd0);

        ARESETn = 1'b1;
        link_en = 1'b1;
        tick();
        check("up_link_up", link_up, 32'd1);
        check("up_rx_ready", sp_rx_ready, 32'd1);

        // three flits through an empty FIFO, one cycle latency each
        sp_tx_ready = 1'b1;
        rtr_out_valid = 1'b1; rtr_out_data = 16'h0401;
        tick();
        check("f1_valid", sp_tx_valid, 32'd1);
        check("f1_data", sp_tx_data, 32'h0401);
        check("f1_dest", sp_tx_dest, 32'd1);
        rtr_out_data = 16'h0802;
        tick();
        check("f2_data", sp_tx_data, 32'h0802);
        check("f2_dest", sp_tx_dest, 32'd2);
        rtr_out_data = 16'h0C03;
        tick();
        check("f3_data", sp_tx_data, 32'h0C03);
        check("f3_dest", sp_tx_dest, 32'd3);
        check("f3_level", egr_level, 32'd1);
        rtr_out_valid = 1'b0;
        tick();
        check("f_empty_valid", sp_tx_valid, 32'd0);
        check("f_empty_level", egr_level, 32'd0);

        // ten flits into a stalled FIFO of eight
        sp_tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rtr_out_valid = 1'b1;
            rtr_out_data  = 16'(16'h1000 + i);
            tick();
        end
        rtr_out_valid = 1'b0;
        check("full_level", egr_level, 32'd8);
        check("full_drop", drop_cnt, drop_exp(2));
        check("full_valid", sp_tx_valid, 32'd1);
        check("full_head_stable", sp_tx_data, 32'h1000);

        // full FIFO with simultaneous push and pop
        rtr_out_valid = 1'b1; rtr_out_data = 16'h2222; sp_tx_ready = 1'b1;
        tick();
        rtr_out_valid = 1'b0;
        check("pp_level", egr_level, 32'd8);
        check("pp_drop", drop_cnt, drop_exp(2));
        check("pp_head", sp_tx_data, 32'h1001);
        for (int k = 0; k < 8; k++) begin
            exp_data = (k < 7) ? 16'(16'h1001 + k) : 16'h2222;
            check("drain8_valid", sp_tx_valid, 32'd1);
            check("drain8_data", sp_tx_data, 32'(exp_data));
            tick();
        end
        check("drain8_done_valid", sp_tx_valid, 32'd0);
        check("drain8_done_level", egr_level, 32'd0);

        // link drop with four flits queued
        sp_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rtr_out_valid = 1'b1;
            rtr_out_data  = 16'(16'h3000 + i);
            tick();
        end
        rtr_out_valid = 1'b0;
        link_en = 1'b0;
        tick();
        check("dr_link_up", link_up, 32'd0);
        check("dr_rx_ready", sp_rx_ready, 32'd0);
        check("dr_tx_valid", sp_tx_valid, 32'd1);
        check("dr_level", egr_level, 32'd4);
        rtr_out_valid = 1'b1; rtr_out_data = 16'h3333;
        tick(); tick();
        rtr_out_valid = 1'b0;
        check("dr_level_nopush", egr_level, 32'd4);
        check("dr_drop", drop_cnt, drop_exp(4));
        sp_tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("dr_out_valid", sp_tx_valid, 32'd1);
            check("dr_out_data", sp_tx_data, 32'(16'h3000 + k));
            tick();
        end
        check("dr_empty_valid", sp_tx_valid, 32'd0);
        check("dr_empty_level", egr_level, 32'd0);
        tick();
        check("dis_link_up", link_up, 32'd0);
        check("dis_rx_ready", sp_rx_ready, 32'd0);

        // ingress pacing with RX_GAP = 2
        link_en = 1'b1;
        tick();
        check("rx_link_up", link_up, 32'd1);
        check("rx_ready0", sp_rx_ready, 32'd1);
        sp_rx_valid = 1'b1; sp_rx_data = 16'hFC10;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("rx_pulse", rtr_in_valid, ((k % 3) == 0) ? 32'd1 : 32'd0);
            check("rx_ready", sp_rx_ready, ((k % 3) == 2) ? 32'd1 : 32'd0);
            if ((k % 3) == 0) begin
                check("rx_dest", rtr_in_dest_addr, 32'h3F);
                check("rx_data", rtr_in_data, 32'hFC10);
            end
        end

        // asynchronous reset in the middle of a burst
        sp_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rtr_out_valid = 1'b1;
            rtr_out_data  = 16'(16'h4000 + i);
            tick();
        end
        check("mid_level_pre", egr_level, 32'd3);
        #2;
        ARESETn = 1'b0;
        #1;
        check("ar_link_up", link_up, 32'd0);
        check("ar_level", egr_level, 32'd0);
        check("ar_tx_valid", sp_tx_valid, 32'd0);
        check("ar_tx_data", sp_tx_data, 32'd0);
        check("ar_tx_dest", sp_tx_dest, 32'd0);
        check("ar_rx_ready", sp_rx_ready, 32'd0);
        check("ar_rin_valid", rtr_in_valid, 32'd0);
        check("ar_rin_data", rtr_in_data, 32'd0);
        check("ar_drop", drop_cnt, 32'd0);
        rtr_out_valid = 1'b0; sp_rx_valid = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();
        check("post_link_up", link_up, 32'd1);
        check("post_level", egr_level, 32'd0);
        check("post_tx_valid", sp_tx_valid, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
